cache_slice_wb: RTL and testbench
=================================

# cache_slice_wb

Parametrised, fully-associative, write-back cache slice with one 32-bit word per line, serving one bank of a set-interleaved data cache. Sits between the requesting core port (rc_*) and main memory: read misses fetch through the cm_* read port, and dirty victims go out through the shared write-back FIFO. Adds configurable depth and set-field width, write-allocate without fetch, an explicit flush sweep, and hit/miss counters.

## Interface
- DEPTH, 256, number of lines; power of two, 2..256; IW = log2(DEPTH)
- SET_BITS, 2, width of the set-select address field Addr[SET_BITS+1:2]; 1..4
- SET_ID, 0, this slice's set number, emitted in write-back records
- CLK  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- rc_Valid  in  1  request strobe; accepted only while rc_Busy=0
- rc_RW  in  1  0 read, 1 write
- rc_Addr  in  32  byte address; tag = Addr[31:SET_BITS+2], TW = 30-SET_BITS
- rc_WriteData  in  32  write data
- rc_ReadData  out  32  read result, valid only with rc_ReadReady
- rc_ReadReady  out  1  one-cycle pulse per completed read
- rc_Busy  out  1  state != IDLE, decoded from the state register
- flush_req  in  1  level; held high until flush_done
- flush_done  out  1  one-cycle pulse at end of sweep
- cm_ReadValid  out  1  one-cycle memory read request pulse
- cm_ReadAddr  out  32  {rc_Addr[31:2],2'b00}; 0 when cm_ReadValid=0
- cm_ReadReady  in  1  memory data valid; ignored outside FILL
- cm_ReadData  in  32  memory read data
- FIFO_we  out  1  one-cycle write strobe
- FIFO_wd  out  64  {DATA, tag[TW-1:0], SET_ID[SET_BITS-1:0], 2'b00}; 0 when FIFO_we=0
- FIFO_full  in  1  FIFO cannot accept; FIFO_we never asserts while FIFO_full=1
- hit_count  out  32  saturating lookup-hit counter
- miss_count  out  32  saturating lookup-miss counter

## Operation
- Per line state: V, D, TAG[TW], DATA[32]. Victim pointer RepPtr[IW] is round-robin: it advances by 1 on every install and wraps from DEPTH-1 to 0. Flush and hit-writes do not move it.
- IDLE:
  - rc_Valid=1: latch RW, Addr, WriteData; go to LOOKUP.
  - Otherwise flush_req=1: clear scan index; go to FLUSH.
  - Both high in the same cycle: the request wins; the flush starts when IDLE is next reached.
- LOOKUP (1 cycle): hit = any line with V=1 and a matching TAG. The tag store must never hold two valid copies of one tag.
  - Read hit: drive DATA on rc_ReadData; pulse rc_ReadReady.
  - Write hit: write DATA, set D=1. Go to IDLE.
  - Read miss: pulse cm_ReadValid; go to FILL.
  - Write miss: go to INSTALL path with the write data. No memory fetch.
  - Every LOOKUP increments exactly one of hit_count or miss_count.
- FILL: wait for cm_ReadReady, then capture cm_ReadData and take the INSTALL path.
- INSTALL path, victim = RepPtr:
  - Victim V&D and FIFO_full=1: go to EVICT_WAIT, holding the new data.
  - Victim V&D and FIFO_full=0: emit the victim record on FIFO, then install.
  - Victim clean: install with no FIFO write.
  - Install: TAG, DATA, V=1, D=RW. Reads also pulse rc_ReadReady with the fill data.
  - Then advance RepPtr and go to IDLE.
- EVICT_WAIT: when FIFO_full=0, write the victim record, install, and go to IDLE.
- FLUSH: one index per cycle, 0..DEPTH-1.
  - V&D line with FIFO_full=1: stall on that index.
  - V&D line otherwise: write its record and clear D.
  - Clean or invalid line: skip. Lines stay valid.
  - After index DEPTH-1: pulse flush_done; go to IDLE.
- Reset at any time: state IDLE; every V, D, TAG and DATA cleared; RepPtr and counters 0. An in-flight miss or flush is abandoned. A cm_ReadReady arriving after reset is ignored.

## Timing
- Reset values: all outputs 0. rc_Busy=0.
- Read hit: rc_Valid sampled at edge 0; LOOKUP during cycle 1; rc_ReadReady high during cycle 2. rc_Busy falls in cycle 2.
- Read miss: cm_ReadValid high during cycle 2. If cm_ReadReady is sampled high at edge N, rc_ReadReady and any FIFO_we are high during cycle N+1.
- Write (hit, or miss with clean victim): complete by cycle 2; no rc_ReadReady.
- FIFO_we coincides with the install cycle. After EVICT_WAIT it asserts in the cycle after FIFO_full is sampled low.
- Flush of K dirty lines with no stalls: exactly DEPTH cycles in FLUSH, then flush_done.

## Test plan
- DEPTH=4:
  - Read 0x100 miss, memory returns 0xAAAA5555 after 3 cycles -> one cm_ReadValid with addr 0x100, then rc_ReadData=0xAAAA5555, miss_count=1.
  - Read 0x100 again -> hit, latency 2, hit_count=1, no cm_ReadValid.
- DEPTH=4, SET_BITS=2, SET_ID=1:
  - Write-miss 0x010,0x020,0x030,0x040, then write-miss 0x050 -> FIFO_wd={data@0x010, tag 0x0000001, 2'b01, 2'b00}. RepPtr wraps to 1.
- Same as above with FIFO_full held for 5 cycles -> FSM holds in EVICT_WAIT, rc_Busy=1, no FIFO_we until FIFO_full=0, then exactly one FIFO_we.
- Three dirty lines, flush_req -> three FIFO writes in index order, flush_done after DEPTH cycles; re-reading those lines hits without FIFO traffic.
- Reset asserted while in FILL -> all outputs 0 immediately; a later cm_ReadReady produces no rc_ReadReady; next read misses.

Source files
------------

// File: rtl/cache_slice_wb.sv
// cache_slice_wb
//   Fully-associative, write-back cache slice holding one 32-bit word per
//   line. It serves one set of a set-interleaved data cache. Read misses
//   fetch through the cm_* read port. Dirty victims leave through the
//   shared write-back FIFO. Write misses allocate without a fetch, and an
//   explicit flush sweep writes back every dirty line.
//
// Parameters
//   DEPTH    number of lines (power of two, 2..256)
//   SET_BITS width of the set-select field Addr[SET_BITS+1:2] (1..4)
//   SET_ID   set number of this slice, inserted in write-back records
//
// Ports
//   CLK, Reset        clock (rising edge), asynchronous active-high reset
//   rc_*              core request port: Valid/RW/Addr/WriteData in,
//                     ReadData/ReadReady/Busy out
//   flush_req/done    level flush request, one-cycle completion pulse
//   cm_*              memory read port: ReadValid/ReadAddr out,
//                     ReadReady/ReadData in
//   FIFO_we/wd/full   write-back FIFO; record layout is
//                     {DATA, TAG, SET_ID, 2'b00}
//   hit_count/miss_count  saturating lookup counters
module cache_slice_wb #(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned SET_BITS = 2,
    parameter int unsigned SET_ID   = 0
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        rc_Valid,
    input  logic        rc_RW,
    input  logic [31:0] rc_Addr,
    input  logic [31:0] rc_WriteData,
    output logic [31:0] rc_ReadData,
    output logic        rc_ReadReady,
    output logic        rc_Busy,
    input  logic        flush_req,
    output logic        flush_done,
    output logic        cm_ReadValid,
    output logic [31:0] cm_ReadAddr,
    input  logic        cm_ReadReady,
    input  logic [31:0] cm_ReadData,
    output logic        FIFO_we,
    output logic [63:0] FIFO_wd,
    input  logic        FIFO_full,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned TW = 30 - SET_BITS;
    localparam logic [SET_BITS-1:0] SET_FIELD = SET_BITS'(SET_ID);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FILL,
        S_EVICT_WAIT,
        S_FLUSH
    } state_t;

    state_t            state_q;

    // Line storage
    logic [DEPTH-1:0]  v_q;
    logic [DEPTH-1:0]  d_q;
    logic [TW-1:0]     tag_q  [DEPTH];
    logic [31:0]       data_q [DEPTH];

    logic [IW-1:0]     rep_q;
    logic [IW-1:0]     flush_idx_q;

    // Latched request; addr_q holds Addr[31:2]
    logic              rw_q;
    logic [29:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       hold_q;

    // Registered outputs
    logic [31:0]       rd_data_q;
    logic              rd_ready_q;
    logic              flush_done_q;
    logic              mem_valid_q;
    logic [31:0]       mem_addr_q;
    logic              fifo_we_q;
    logic [63:0]       fifo_wd_q;
    logic [31:0]       hit_cnt_q;
    logic [31:0]       miss_cnt_q;

    // Byte offset never affects a word-granular cache
    logic              unused_addr_lsbs;
    assign unused_addr_lsbs = ^rc_Addr[1:0];

    // Lookup
    logic [TW-1:0]     lk_tag;
    logic              hit;
    logic [IW-1:0]     hit_idx;

    always_comb begin
        lk_tag  = addr_q[29:SET_BITS];
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (v_q[i] && (tag_q[i] == lk_tag)) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // Install path, entered from a write miss in LOOKUP, a memory return in
    // FILL, or a retry from EVICT_WAIT. The victim is always rep_q.
    logic              inst_req;
    logic [31:0]       inst_data;
    logic              vic_dirty;
    logic              inst_stall;
    logic              inst_go;
    logic [63:0]       vic_rec;
    logic              fl_dirty;
    logic [63:0]       fl_rec;

    always_comb begin
        inst_req  = 1'b0;
        inst_data = wdata_q;
        case (state_q)
            S_LOOKUP:     inst_req = ~hit & rw_q;
            S_FILL: begin
                inst_req  = cm_ReadReady;
                inst_data = cm_ReadData;
            end
            S_EVICT_WAIT: begin
                inst_req  = 1'b1;
                inst_data = hold_q;
            end
            default:      inst_req = 1'b0;
        endcase
        vic_dirty  = v_q[rep_q] & d_q[rep_q];
        inst_stall = inst_req & vic_dirty & FIFO_full;
        inst_go    = inst_req & ~inst_stall;
        vic_rec    = {data_q[rep_q], tag_q[rep_q], SET_FIELD, 2'b00};
        fl_dirty   = v_q[flush_idx_q] & d_q[flush_idx_q];
        fl_rec     = {data_q[flush_idx_q], tag_q[flush_idx_q], SET_FIELD, 2'b00};
    end

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == '1) ? c : c + 32'd1;
    endfunction

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            v_q          <= '0;
            d_q          <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
            rep_q        <= '0;
            flush_idx_q  <= '0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            hold_q       <= '0;
            rd_data_q    <= '0;
            rd_ready_q   <= 1'b0;
            flush_done_q <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            fifo_we_q    <= 1'b0;
            fifo_wd_q    <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            rd_ready_q   <= 1'b0;
            flush_done_q <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            fifo_we_q    <= 1'b0;
            fifo_wd_q    <= '0;

            case (state_q)
                S_IDLE: begin
                    if (rc_Valid) begin
                        rw_q    <= rc_RW;
                        addr_q  <= rc_Addr[31:2];
                        wdata_q <= rc_WriteData;
                        state_q <= S_LOOKUP;
                    // flush_req is still high while flush_done is pulsing;
                    // do not mistake that for a fresh request
                    end else if (flush_req && !flush_done_q) begin
                        flush_idx_q <= '0;
                        state_q     <= S_FLUSH;
                    end
                end

                S_LOOKUP: begin
                    if (hit) begin
                        hit_cnt_q <= sat_inc(hit_cnt_q);
                        if (rw_q) begin
                            data_q[hit_idx] <= wdata_q;
                            d_q[hit_idx]    <= 1'b1;
                        end else begin
                            rd_data_q  <= data_q[hit_idx];
                            rd_ready_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end else begin
                        miss_cnt_q <= sat_inc(miss_cnt_q);
                        if (!rw_q) begin
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= {addr_q, 2'b00};
                            state_q     <= S_FILL;
                        end
                    end
                end

                S_FLUSH: begin
                    if (!(fl_dirty && FIFO_full)) begin
                        if (fl_dirty) begin
                            fifo_we_q          <= 1'b1;
                            fifo_wd_q          <= fl_rec;
                            d_q[flush_idx_q]   <= 1'b0;
                        end
                        if (flush_idx_q == IW'(DEPTH - 1)) begin
                            flush_done_q <= 1'b1;
                            state_q      <= S_IDLE;
                        end
                        flush_idx_q <= flush_idx_q + 1'b1;
                    end
                end

                default: ;
            endcase

            // Shared install path; overrides the state chosen above
            if (inst_go) begin
                if (vic_dirty) begin
                    fifo_we_q <= 1'b1;
                    fifo_wd_q <= vic_rec;
                end
                v_q[rep_q]    <= 1'b1;
                d_q[rep_q]    <= rw_q;
                tag_q[rep_q]  <= lk_tag;
                data_q[rep_q] <= inst_data;
                if (!rw_q) begin
                    rd_data_q  <= inst_data;
                    rd_ready_q <= 1'b1;
                end
                rep_q   <= rep_q + 1'b1;
                state_q <= S_IDLE;
            end else if (inst_stall) begin
                hold_q  <= inst_data;
                state_q <= S_EVICT_WAIT;
            end
        end
    end

    assign rc_ReadData  = rd_data_q;
    assign rc_ReadReady = rd_ready_q;
    assign rc_Busy      = (state_q != S_IDLE);
    assign flush_done   = flush_done_q;
    assign cm_ReadValid = mem_valid_q;
    assign cm_ReadAddr  = mem_addr_q;
    assign FIFO_we      = fifo_we_q;
    assign FIFO_wd      = fifo_wd_q;
    assign hit_count    = hit_cnt_q;
    assign miss_count   = miss_cnt_q;

endmodule

// File: tb/tb_cache_slice_wb.sv
// Testbench for cache_slice_wb (DEPTH=4, SET_BITS=2, SET_ID=1).
// Directed scenarios followed by randomized traffic, each transaction
// checked against a transaction-level cache model.
module tb_cache_slice_wb;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SB    = 2;
    localparam int unsigned SID   = 1;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        rc_Valid = 1'b0;
    logic        rc_RW = 1'b0;
    logic [31:0] rc_Addr = '0;
    logic [31:0] rc_WriteData = '0;
    logic [31:0] rc_ReadData;
    logic        rc_ReadReady;
    logic        rc_Busy;
    logic        flush_req = 1'b0;
    logic        flush_done;
    logic        cm_ReadValid;
    logic [31:0] cm_ReadAddr;
    logic        cm_ReadReady = 1'b0;
    logic [31:0] cm_ReadData = '0;
    logic        FIFO_we;
    logic [63:0] FIFO_wd;
    logic        FIFO_full = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    cache_slice_wb #(.DEPTH(DEPTH), .SET_BITS(SB), .SET_ID(SID)) dut (
        .CLK(CLK), .Reset(Reset),
        .rc_Valid(rc_Valid), .rc_RW(rc_RW), .rc_Addr(rc_Addr),
        .rc_WriteData(rc_WriteData), .rc_ReadData(rc_ReadData),
        .rc_ReadReady(rc_ReadReady), .rc_Busy(rc_Busy),
        .flush_req(flush_req), .flush_done(flush_done),
        .cm_ReadValid(cm_ReadValid), .cm_ReadAddr(cm_ReadAddr),
        .cm_ReadReady(cm_ReadReady), .cm_ReadData(cm_ReadData),
        .FIFO_we(FIFO_we), .FIFO_wd(FIFO_wd), .FIFO_full(FIFO_full),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: one entry per line slot plus round-robin pointer
    logic        mv    [DEPTH];
    logic        md    [DEPTH];
    logic [27:0] mtag  [DEPTH];
    logic [31:0] mdata [DEPTH];
    int unsigned mptr, m_hits, m_miss;
    logic [63:0] last_rec;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all_zero(input string tag);
        logic [196:0] o;
        o = {rc_ReadData, rc_ReadReady, rc_Busy, flush_done, cm_ReadValid, cm_ReadAddr,
             FIFO_we, FIFO_wd, hit_count, miss_count};
        n_checks++;
        assert (o === '0) n_pass++;
        else $error("FAIL %s observed=%0h expected=0", tag, o);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mv[i] = 1'b0; md[i] = 1'b0; mtag[i] = '0; mdata[i] = '0;
        end
        mptr = 0; m_hits = 0; m_miss = 0;
    endtask

    // One request. full_cyc: FIFO_full is high for request cycles 1..full_cyc.
    // mem_delay: cycles from cm_ReadValid to the cm_ReadReady pulse.
    task automatic do_req(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                          input int unsigned mem_delay, input int unsigned full_cyc,
                          input logic [31:0] fill);
        logic [27:0] tag;
        logic        exp_hit, vic_dirty, overlap, pend;
        int          hidx, vic;
        logic [63:0] exp_rec, rec;
        logic [31:0] exp_rd, rr_data, rv_addr;
        int unsigned e, done_exp, done_cyc, rd_at, rv_cyc, n_rv, n_we, n_rr, rr_cyc;

        tag = addr[31:SB+2];
        exp_hit = 1'b0; hidx = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mv[i] && mtag[i] == tag) begin exp_hit = 1'b1; hidx = i; end
        vic       = int'(mptr);
        vic_dirty = !exp_hit && mv[vic] && md[vic];
        exp_rec   = {mdata[vic], mtag[vic], 2'(SID), 2'b00};
        if (exp_hit) begin
            exp_rd   = mdata[hidx];
            done_exp = 2;
            if (rw) begin mdata[hidx] = wdata; md[hidx] = 1'b1; end
            m_hits++;
        end else begin
            m_miss++;
            e        = rw ? 1 : 2 + mem_delay;
            done_exp = (vic_dirty && e <= full_cyc) ? full_cyc + 2 : e + 1;
            exp_rd   = fill;
            mv[vic] = 1'b1; md[vic] = rw; mtag[vic] = tag;
            mdata[vic] = rw ? wdata : fill;
            mptr = (mptr + 1) % DEPTH;
        end

        overlap = 1'b0; pend = 1'b0; rec = '0; rr_data = '0; rv_addr = '0;
        done_cyc = 0; rd_at = 0; rv_cyc = 0; n_rv = 0; n_we = 0; n_rr = 0; rr_cyc = 0;
        rc_Valid = 1'b1; rc_RW = rw; rc_Addr = addr; rc_WriteData = wdata;
        FIFO_full = (full_cyc > 0); cm_ReadReady = 1'b0; cm_ReadData = fill;
        tick();
        rc_Valid = 1'b0;
        for (int unsigned c = 1; c <= 60; c++) begin
            FIFO_full = (c <= full_cyc);
            if (FIFO_we && FIFO_full) overlap = 1'b1;
            if (cm_ReadValid) begin n_rv++; rv_cyc = c; rv_addr = cm_ReadAddr; pend = 1'b1; rd_at = c + mem_delay; end
            if (FIFO_we) begin n_we++; rec = FIFO_wd; end
            if (rc_ReadReady) begin n_rr++; rr_cyc = c; rr_data = rc_ReadData; end
            cm_ReadReady = pend && (c == rd_at);
            if (cm_ReadReady) pend = 1'b0;
            if (!rc_Busy) begin done_cyc = c; break; end
            tick();
        end
        cm_ReadReady = 1'b0;
        FIFO_full = 1'b0;
        last_rec = rec;

        check("done_cycle", done_cyc, done_exp);
        check("mem_req_count", n_rv, (!exp_hit && !rw) ? 1 : 0);
        if (!exp_hit && !rw) begin
            check("mem_req_cycle", rv_cyc, 2);
            check("mem_req_addr", rv_addr, {addr[31:2], 2'b00});
        end
        check("read_ready_count", n_rr, rw ? 0 : 1);
        if (!rw) begin
            check("read_ready_cycle", rr_cyc, done_exp);
            check("read_data", rr_data, exp_rd);
        end
        check("fifo_we_count", n_we, vic_dirty ? 1 : 0);
        if (vic_dirty) check("fifo_record", rec, exp_rec);
        check("fifo_we_while_full", overlap, 0);
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_miss);
    endtask

    task automatic do_flush();
        logic [63:0] exp_q[$];
        logic [63:0] got_q[$];
        int unsigned busy_n, done_c;
        for (int i = 0; i < DEPTH; i++)
            if (mv[i] && md[i]) begin
                exp_q.push_back({mdata[i], mtag[i], 2'(SID), 2'b00});
                md[i] = 1'b0;
            end
        flush_req = 1'b1; FIFO_full = 1'b0; cm_ReadReady = 1'b0;
        busy_n = 0; done_c = 0;
        tick();
        for (int unsigned c = 1; c <= 40; c++) begin
            if (rc_Busy) busy_n++;
            if (FIFO_we) got_q.push_back(FIFO_wd);
            if (flush_done) begin done_c = c; break; end
            tick();
        end
        flush_req = 1'b0;
        check("flush_done_cycle", done_c, DEPTH + 1);
        check("flush_busy_cycles", busy_n, DEPTH);
        check("flush_record_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("flush_record", got_q[i], exp_q[i]);
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        tick();
        check_all_zero("reset_outputs");
        Reset = 1'b0;
        model_reset();
        tick();
    endtask

    logic [31:0] ra;
    int unsigned rfull;

    initial begin
        model_reset();
        last_rec = '0;
        #1;
        check_all_zero("power_on_reset_outputs");
        tick();
        tick();
        Reset = 1'b0;
        tick();

        // Read miss with 3-cycle memory latency, then the same address hits
        do_req(1'b0, 32'h0000_0100, 32'h0, 3, 0, 32'hAAAA_5555);
        do_req(1'b0, 32'h0000_0100, 32'h0, 0, 0, 32'h0);

        // Four write misses fill the slice, the fifth evicts 0x010
        apply_reset();
        do_req(1'b1, 32'h0000_0010, 32'hD000_0010, 0, 0, 32'h0);
        do_req(1'b1, 32'h0000_0020, 32'hD000_0020, 0, 0, 32'h0);
        do_req(1'b1, 32'h0000_0030, 32'hD000_0030, 0, 0, 32'h0);
        do_req(1'b1, 32'h0000_0040, 32'hD000_0040, 0, 0, 32'h0);
        do_req(1'b1, 32'h0000_0050, 32'hD000_0050, 0, 0, 32'h0);
        check("first_eviction_record", last_rec, {32'hD000_0010, 28'h000_0001, 2'b01, 2'b00});

        // Victim 0x020 is dirty while the FIFO is full for 5 cycles
        do_req(1'b1, 32'h0000_0060, 32'hD000_0060, 0, 5, 32'h0);
        // Read miss whose dirty victim waits on the FIFO after the fill
        do_req(1'b0, 32'h0000_0070, 32'h0, 1, 6, 32'h7777_0070);

        // Three dirty lines flushed, then re-read without FIFO traffic
        do_flush();
        do_req(1'b0, 32'h0000_0050, 32'h0, 0, 0, 32'h0);
        do_req(1'b0, 32'h0000_0060, 32'h0, 0, 0, 32'h0);
        do_req(1'b0, 32'h0000_0040, 32'h0, 0, 0, 32'h0);

        // Reset while waiting for memory; the late return must be ignored
        rc_Valid = 1'b1; rc_RW = 1'b0; rc_Addr = 32'h0000_0200;
        tick();
        rc_Valid = 1'b0;
        tick();
        check("abandon_mem_req", cm_ReadValid, 1);
        tick();
        check("abandon_busy_in_fill", rc_Busy, 1);
        #2 Reset = 1'b1;
        #1;
        check_all_zero("reset_in_fill_outputs");
        @(posedge CLK);
        #1 Reset = 1'b0;
        model_reset();
        cm_ReadReady = 1'b1; cm_ReadData = 32'h1234_5678;
        tick();
        cm_ReadReady = 1'b0;
        check("stale_fill_ignored", {rc_ReadReady, rc_Busy}, 0);
        tick();
        check("stale_fill_ignored_2", {rc_ReadReady, rc_Busy, FIFO_we}, 0);
        do_req(1'b0, 32'h0000_0200, 32'h0, 2, 0, 32'h0BAD_F00D);

        // Randomized traffic over a small tag pool so hits and evictions mix
        for (int n = 0; n < 200; n++) begin
            if (n % 25 == 24) begin
                do_flush();
            end else begin
                ra    = ($urandom_range(1, 9) << 4) | $urandom_range(0, 15);
                rfull = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
                do_req(1'($urandom_range(0, 1)), ra, $urandom, $urandom_range(0, 4), rfull, $urandom);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
